regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32x32 register file. Shares the single register-file write port between the in-order pipeline writeback stage (requester A) and the long-latency unit (requester B, mul/div or load return). It uses valid/ready handshakes, fixed priority to A with an anti-starvation age counter for B, and registered write outputs. The outputs drive the register file's `RDaddr_i`/`RDdata_i`/`RegWrite_i` directly.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and request type for the register-file write path.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register for outstanding B writes, plus source-operand hazard check.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic                  hazard_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    // set after clear so a same-cycle issue to the committing register stays busy
    if (set_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign hazard_o = busy_q[rs_addr_i] || busy_q[rt_addr_i];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback (A) and the long-latency unit (B).
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard and its hazard ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  a_valid_i,
  input  logic [REG_ADDR_W-1:0] a_addr_i,
  input  logic [REG_DATA_W-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [REG_ADDR_W-1:0] b_addr_i,
  input  logic [REG_DATA_W-1:0] b_data_i,
  output logic                  b_ready_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic [REG_DATA_W-1:0] RDdata_o,
  output logic                  RegWrite_o,
  output logic                  stall_o
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                  b_issue_i,
  input  logic [REG_ADDR_W-1:0] b_issue_addr_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  output logic                  hazard_o
`endif
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  wb_req_t a_req, b_req, sel;
  logic [3:0] wait_q, wait_d;
  logic aged, grant_a, grant_b;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [REG_DATA_W-1:0] rd_data_q, rd_data_d;
  logic we_q, we_d;
  always_comb begin
    a_req = {a_valid_i, a_addr_i, a_data_i};
    b_req = {b_valid_i, b_addr_i, b_data_i};
    aged = wait_q == MAX_W;
    grant_b = !reset && b_req.valid && (aged || !a_req.valid);
    grant_a = !reset && a_req.valid && !grant_b;
    sel = grant_b ? b_req : a_req;
    sel.valid = grant_a || grant_b;
    wait_d = (b_req.valid && !grant_b) ? (aged ? wait_q : wait_q + 4'd1) : 4'd0;
    rd_addr_d = sel.valid ? sel.addr : rd_addr_q;
    rd_data_d = sel.valid ? sel.data : rd_data_q;
    // x0 writes finish the handshake but never reach the register file
    we_d = sel.valid && sel.addr != '0;
  end
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
    end
  end
  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign stall_o    = !reset && aged && b_valid_i;
  assign RDaddr_o   = rd_addr_q;
  assign RDdata_o   = rd_data_q;
  assign RegWrite_o = we_q;
`ifdef REGFILE_SCOREBOARD_EN
  logic src_b_q;
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) src_b_q <= 1'b0;
    else if (sel.valid) src_b_q <= grant_b;
  end
  regfile_scoreboard u_sb (
    .clk_i      (clk_i),
    .reset      (reset),
    .set_i      (b_issue_i),
    .set_addr_i (b_issue_addr_i),
    .clr_i      (we_q && src_b_q),
    .clr_addr_i (rd_addr_q),
    .rs_addr_i  (rs_addr_i),
    .rt_addr_i  (rt_addr_i),
    .hazard_o   (hazard_o)
  );
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the write-port arbiter against a refusal-count model.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;
  logic clk_i = 1'b0, reset = 1'b1;
  logic a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic [4:0] a_addr_i = '0, b_addr_i = '0;
  logic [31:0] a_data_i = '0, b_data_i = '0;
  logic a_ready_o, b_ready_o, RegWrite_o, stall_o;
  logic [4:0] RDaddr_o;
  logic [31:0] RDdata_o;
`ifdef REGFILE_SCOREBOARD_EN
  logic b_issue_i = 1'b0;
  logic [4:0] b_issue_addr_i = '0, rs_addr_i = '0, rt_addr_i = '0;
  logic hazard_o;
`endif
  int checks = 0, errors = 0;
  int m_refused;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  logic m_we;
  logic e_ar, e_br, e_st, o_ar, o_br, o_st;
  always #5 clk_i = ~clk_i;
  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .reset(reset),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o), .stall_o(stall_o)
`ifdef REGFILE_SCOREBOARD_EN
    , .b_issue_i(b_issue_i), .b_issue_addr_i(b_issue_addr_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .hazard_o(hazard_o)
`endif
  );
  task automatic model_reset();
    m_refused = 0;
    m_addr = '0;
    m_data = '0;
    m_we = 1'b0;
  endtask
  task automatic predict();
    e_st = !reset && b_valid_i && m_refused >= MAX_WAIT;
    e_br = !reset && b_valid_i && (e_st || !a_valid_i);
    e_ar = !reset && a_valid_i && !e_br;
  endtask
  task automatic commit();
    if (reset) model_reset();
    else begin
      if (e_ar || e_br) begin
        m_addr = e_br ? b_addr_i : a_addr_i;
        m_data = e_br ? b_data_i : a_data_i;
      end
      m_we = (e_ar || e_br) && m_addr != 5'd0;
      m_refused = (b_valid_i && !e_br) ? m_refused + 1 : 0;
    end
  endtask
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    @(negedge clk_i);
    a_valid_i = av; a_addr_i = aa; a_data_i = ad;
    b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
    #1;
    predict();
    o_ar = a_ready_o; o_br = b_ready_o; o_st = stall_o;
    @(posedge clk_i);
    commit();
    #1;
  endtask
  task automatic test_reset();
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({a_ready_o, b_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got ar=%b br=%b st=%b we=%b addr=%0d data=%h exp all 0",
               a_ready_o, b_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o);
    end
    @(negedge clk_i);
    reset = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
    model_reset();
  endtask
  task automatic test_a_single();
    step(0, 0, 0, 0, 0, 0);
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if ({o_ar, o_br} !== 2'b10) begin
      errors++; $display("FAIL a_single_ready got ar=%b br=%b exp ar=1 br=0", o_ar, o_br);
    end
    checks++;
    if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL a_single_out got we=%b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", RegWrite_o, RDaddr_o, RDdata_o);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL a_single_hold got we=%b addr=%0d data=%h exp we=0 addr=5 data=deadbeef", RegWrite_o, RDaddr_o, RDdata_o);
    end
  endtask
  task automatic test_starvation();
    logic [2:0] exp;
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 5'(i + 1), $urandom, 1, 9, 32'hB0B0_0009);
      exp = (i == 4) ? 3'b011 : 3'b100;
      checks++;
      if ({o_ar, o_br, o_st} !== exp || {o_ar, o_br, o_st} !== {e_ar, e_br, e_st}) begin
        errors++; $display("FAIL starve_grant[%0d] got ar/br/st=%b exp %b", i, {o_ar, o_br, o_st}, exp);
      end
      checks++;
      if ({RegWrite_o, RDaddr_o, RDdata_o} !== {m_we, m_addr, m_data}) begin
        errors++; $display("FAIL starve_out[%0d] got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h", i, RegWrite_o, RDaddr_o, RDdata_o, m_we, m_addr, m_data);
      end
    end
    checks++;
    if (RDaddr_o !== 5'd6) begin
      errors++; $display("FAIL starve_after got addr=%0d exp 6", RDaddr_o);
    end
  endtask
  task automatic test_x0();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h1234);
    checks++;
    if (o_br !== 1'b1) begin
      errors++; $display("FAIL x0_ready got br=%b exp 1", o_br);
    end
    checks++;
    if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b0, 5'd0, 32'h1234}) begin
      errors++; $display("FAIL x0_drop got we=%b addr=%0d data=%h exp we=0 addr=0 data=1234", RegWrite_o, RDaddr_o, RDdata_o);
    end
  endtask
  task automatic test_back_to_back();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 5'(i), 32'hA000_0000 + i, 0, 0, 0);
      checks++;
      if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'(i), 32'hA000_0000 + i}) begin
        errors++; $display("FAIL b2b[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d", i, RegWrite_o, RDaddr_o, RDdata_o, i);
      end
    end
  endtask
  task automatic test_reset_midway();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 5'(i + 10), $urandom, 1, 3, 32'h3333);
    reset = 1'b1;
    #1;
    checks++;
    if ({a_ready_o, b_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o} !== '0) begin
      errors++; $display("FAIL midreset_state got ar=%b br=%b st=%b we=%b addr=%0d data=%h exp all 0", a_ready_o, b_ready_o, stall_o, RegWrite_o, RDaddr_o, RDdata_o);
    end
    step(1, 12, 32'h1, 1, 3, 32'h3333);
    checks++;
    if ({o_ar, o_br, o_st, RegWrite_o} !== 4'b0000) begin
      errors++; $display("FAIL midreset_held got ar/br/st/we=%b exp 0000", {o_ar, o_br, o_st, RegWrite_o});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 5'(i + 20), $urandom, 1, 3, 32'h3333);
      checks++;
      if ({o_ar, o_br} !== ((i == 4) ? 2'b01 : 2'b10) || {o_ar, o_br, o_st} !== {e_ar, e_br, e_st}) begin
        errors++; $display("FAIL midreset_regrant[%0d] got ar/br/st=%b exp %b", i, {o_ar, o_br, o_st}, {e_ar, e_br, e_st});
      end
    end
    step(1, 7, 32'h7, 1, 4, 32'h4444);
    step(0, 0, 0, 1, 4, 32'h4444);
    checks++;
    if (o_br !== 1'b1 || RDaddr_o !== 5'd4) begin
      errors++; $display("FAIL midreset_a_idle got br=%b addr=%0d exp br=1 addr=4", o_br, RDaddr_o);
    end
  endtask
  task automatic test_random();
    logic av = 0, bv = 0;
    logic [4:0] aa = 0, ba = 0;
    logic [31:0] ad = 0, bd = 0;
    step(0, 0, 0, 0, 0, 0);
    o_ar = 0; o_br = 0;
    for (int i = 0; i < 300; i++) begin
      if (!(av && !o_ar)) begin
        av = 1'($urandom_range(0, 1)); aa = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!(bv && !o_br)) begin
        bv = 1'($urandom_range(0, 1)); ba = 5'($urandom_range(0, 31)); bd = $urandom;
      end
      step(av, aa, ad, bv, ba, bd);
      checks++;
      if ({o_ar, o_br, o_st} !== {e_ar, e_br, e_st}) begin
        errors++; $display("FAIL rand_grant[%0d] got ar/br/st=%b exp %b", i, {o_ar, o_br, o_st}, {e_ar, e_br, e_st});
      end
      checks++;
      if ({RegWrite_o, RDaddr_o, RDdata_o} !== {m_we, m_addr, m_data}) begin
        errors++; $display("FAIL rand_out[%0d] got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h", i, RegWrite_o, RDaddr_o, RDdata_o, m_we, m_addr, m_data);
      end
    end
  endtask
`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard();
    step(0, 0, 0, 0, 0, 0);
    rs_addr_i = 7; rt_addr_i = 0;
    b_issue_i = 1; b_issue_addr_i = 7;
    step(0, 0, 0, 0, 0, 0);
    b_issue_i = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hazard_o !== 1'b1) begin errors++; $display("FAIL sb_busy[%0d] got %b exp 1", i, hazard_o); end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 7, 32'h77);
    checks++;
    if (hazard_o !== 1'b1) begin errors++; $display("FAIL sb_commit_cycle got %b exp 1", hazard_o); end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (hazard_o !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b exp 0", hazard_o); end
    b_issue_i = 1;
    step(0, 0, 0, 0, 0, 0);
    b_issue_i = 0;
    step(0, 0, 0, 1, 7, 32'h78);
    b_issue_i = 1;
    step(0, 0, 0, 0, 0, 0);
    b_issue_i = 0;
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (hazard_o !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", hazard_o); end
    rs_addr_i = 0; b_issue_i = 1; b_issue_addr_i = 0;
    step(0, 0, 0, 0, 0, 0);
    b_issue_i = 0;
    checks++;
    if (hazard_o !== 1'b0) begin errors++; $display("FAIL sb_x0 got %b exp 0", hazard_o); end
  endtask
`endif
  initial begin
    model_reset();
    test_reset();
    test_a_single();
    test_starvation();
    test_x0();
    test_back_to_back();
    test_reset_midway();
    test_random();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
